irq_sequencer: RTL and testbench

IRQ_SEQUENCER -- requirements
Module: irq_sequencer

---
 rtl/irq_pkg.sv | 87 ++++++++
 rtl/irq_sequencer_if.sv | 32 +++
 rtl/nmi_edge.sv | 31 +++
 rtl/irq_sequencer.sv | 118 +++++++++++
 tb/tb_irq_sequencer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt/reset entry sequencer:
// state and cause encodings, stack-source select, vector bases, control decode.
package irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_PCH = 3'd1,
    ST_PUSH_PCL = 3'd2,
    ST_PUSH_P   = 3'd3,
    ST_VEC_LO   = 3'd4,
    ST_VEC_HI   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_RESET = 2'd1,
    CAUSE_NMI   = 2'd2,
    CAUSE_IRQ   = 2'd3
  } cause_t;

  typedef enum logic [1:0] {
    PSEL_PCH  = 2'd0,
    PSEL_PCL  = 2'd1,
    PSEL_P    = 2'd2,
    PSEL_NONE = 2'd3
  } push_sel_t;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  typedef struct packed {
    logic        active;
    push_sel_t   push_sel;
    logic        mem_write;
    logic        sp_dec;
    logic        b_flag;
    logic [15:0] vec_addr;
    logic        pcl_load;
    logic        pch_load;
    logic        set_i;
    logic        done;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{active: 1'b0, push_sel: PSEL_NONE, mem_write: 1'b0,
                                sp_dec: 1'b0, b_flag: 1'b0, vec_addr: 16'h0000,
                                pcl_load: 1'b0, pch_load: 1'b0, set_i: 1'b0, done: 1'b0};

  function automatic logic [15:0] vec_base(input cause_t c);
    logic [15:0] b;
    case (c)
      CAUSE_RESET: b = VEC_RESET;
      CAUSE_NMI:   b = VEC_NMI;
      CAUSE_IRQ:   b = VEC_IRQ;
      default:     b = 16'h0000;
    endcase
    return b;
  endfunction

  function automatic ctl_t decode_ctl(input state_t s, input cause_t c, input logic brk);
    ctl_t o;
    o = CTL_IDLE;
    case (s)
      ST_PUSH_PCH: begin o.active = 1'b1; o.push_sel = PSEL_PCH; o.sp_dec = 1'b1; end
      ST_PUSH_PCL: begin o.active = 1'b1; o.push_sel = PSEL_PCL; o.sp_dec = 1'b1; end
      ST_PUSH_P: begin
        o.active   = 1'b1;
        o.push_sel = PSEL_P;
        o.sp_dec   = 1'b1;
        o.b_flag   = brk;
      end
      ST_VEC_LO: begin o.active = 1'b1; o.vec_addr = vec_base(c); o.pcl_load = 1'b1; end
      ST_VEC_HI: begin
        o.active   = 1'b1;
        o.vec_addr = vec_base(c) + 16'd1;
        o.pch_load = 1'b1;
        o.set_i    = 1'b1;
        o.done     = 1'b1;
      end
      default: o = CTL_IDLE;
    endcase
    // Reset entry performs dummy pushes: the stack pointer moves but nothing is written.
    o.mem_write = o.sp_dec & (c != CAUSE_RESET);
    return o;
  endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// Request inputs and datapath control outputs of the interrupt sequencer.
interface irq_sequencer_if;
  logic        insn_boundary;
  logic        ready;
  logic        nmi_n;
  logic        irq_n;
  logic        brk_req;
  logic        i_flag;
  logic        active;
  logic [1:0]  cause;
  logic [1:0]  push_sel;
  logic        mem_write;
  logic        sp_dec;
  logic        b_flag;
  logic [15:0] vec_addr;
  logic        pcl_load;
  logic        pch_load;
  logic        set_i;
  logic        done;

  modport slave (
    input  insn_boundary, ready, nmi_n, irq_n, brk_req, i_flag,
    output active, cause, push_sel, mem_write, sp_dec, b_flag, vec_addr,
           pcl_load, pch_load, set_i, done
  );

  modport master (
    output insn_boundary, ready, nmi_n, irq_n, brk_req, i_flag,
    input  active, cause, push_sel, mem_write, sp_dec, b_flag, vec_addr,
           pcl_load, pch_load, set_i, done
  );
endinterface

// File: rtl/nmi_edge.sv
// NMI falling-edge detector with a sticky request latch; frozen while ready=0
// so an edge arriving during a stall is seen once ready returns.
module nmi_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ready,
  input  logic i_nmi_n,
  input  logic i_clr,
  output logic o_pending
);

  logic r_nmi_prev;
  logic r_pending;
  logic w_fall;

  assign w_fall = r_nmi_prev & ~i_nmi_n;

  // Edge history and latch; a fresh edge outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nmi_prev <= 1'b1;
      r_pending  <= 1'b0;
    end else if (i_ready) begin
      r_nmi_prev <= i_nmi_n;
      r_pending  <= w_fall | (r_pending & ~i_clr);
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt/reset entry sequencer: pushes PC and P, then fetches the vector.
// Controls are registered from the next state, so no input reaches an output combinationally.
module irq_sequencer
  import irq_pkg::*;
(
  input  logic            ph2,
  input  logic            reset,
  irq_sequencer_if.slave  bus
);

  state_t r_state, w_state_nx;
  cause_t r_cause, w_cause_nx;
  logic   r_brk, w_brk_nx;
  logic   r_reset_pend, w_reset_pend_nx;
  logic   w_nmi_pend, w_nmi_clr, w_irq_pend;
  ctl_t   r_ctl, w_ctl_nx;

  nmi_edge u_nmi_edge (
    .clk       (ph2),
    .rst_n     (reset),
    .i_ready   (bus.ready),
    .i_nmi_n   (bus.nmi_n),
    .i_clr     (w_nmi_clr),
    .o_pending (w_nmi_pend)
  );

  assign w_irq_pend = ~bus.irq_n & ~bus.i_flag;

  // State register.
  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cause      <= CAUSE_NONE;
      r_brk        <= 1'b0;
      r_reset_pend <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_cause      <= w_cause_nx;
      r_brk        <= w_brk_nx;
      r_reset_pend <= w_reset_pend_nx;
    end
  end

  // Next-state logic; everything holds while ready=0.
  always_comb begin
    w_state_nx      = r_state;
    w_cause_nx      = r_cause;
    w_brk_nx        = r_brk;
    w_reset_pend_nx = r_reset_pend;
    w_nmi_clr       = 1'b0;
    if (bus.ready) begin
      case (r_state)
        ST_IDLE: begin
          if (r_reset_pend) begin
            w_state_nx      = ST_PUSH_PCH;
            w_cause_nx      = CAUSE_RESET;
            w_brk_nx        = 1'b0;
            w_reset_pend_nx = 1'b0;
          end else if (bus.insn_boundary && w_nmi_pend) begin
            w_state_nx = ST_PUSH_PCH;
            w_cause_nx = CAUSE_NMI;
            w_brk_nx   = 1'b0;
            w_nmi_clr  = 1'b1;
          end else if (bus.insn_boundary && (bus.brk_req || w_irq_pend)) begin
            w_state_nx = ST_PUSH_PCH;
            w_cause_nx = CAUSE_IRQ;
            w_brk_nx   = bus.brk_req;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
        ST_PUSH_PCH: w_state_nx = ST_PUSH_PCL;
        ST_PUSH_PCL: w_state_nx = ST_PUSH_P;
        ST_PUSH_P:   w_state_nx = ST_VEC_LO;
        ST_VEC_LO:   w_state_nx = ST_VEC_HI;
        ST_VEC_HI: begin
          w_state_nx = ST_IDLE;
          w_cause_nx = CAUSE_NONE;
          w_brk_nx   = 1'b0;
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_cause_nx = CAUSE_NONE;
          w_brk_nx   = 1'b0;
        end
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  // Output decode of the upcoming state.
  always_comb begin
    w_ctl_nx = decode_ctl(w_state_nx, w_cause_nx, w_brk_nx);
  end

  // Output register.
  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      r_ctl <= CTL_IDLE;
    end else begin
      r_ctl <= w_ctl_nx;
    end
  end

  assign bus.active    = r_ctl.active;
  assign bus.cause     = r_cause;
  assign bus.push_sel  = r_ctl.push_sel;
  assign bus.mem_write = r_ctl.mem_write;
  assign bus.sp_dec    = r_ctl.sp_dec;
  assign bus.b_flag    = r_ctl.b_flag;
  assign bus.vec_addr  = r_ctl.vec_addr;
  assign bus.pcl_load  = r_ctl.pcl_load;
  assign bus.pch_load  = r_ctl.pch_load;
  assign bus.set_i     = r_ctl.set_i;
  assign bus.done      = r_ctl.done;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: per-cycle expected control vectors are queued
// when a request is driven and compared one per clock.
module tb_irq_sequencer;

  logic ph2;
  logic reset;
  int   checks;
  int   errors;

  logic [27:0] exp_q[$];
  string       tag_q[$];

  irq_sequencer_if bus ();

  irq_sequencer dut (
    .ph2   (ph2),
    .reset (reset),
    .bus   (bus)
  );

  initial ph2 = 1'b0;
  always #5 ph2 = ~ph2;

  // Expected {active,cause,push_sel,mem_write,sp_dec,b_flag,vec_addr,pcl,pch,set_i,done}; step 0 = idle.
  function automatic logic [27:0] exp_vec(input int step, input logic [1:0] c, input bit brk);
    logic        act, sp, mw, bf, pl, ph, si, dn;
    logic [1:0]  ps, co;
    logic [15:0] va, base;
    act = 1'b0; sp = 1'b0; bf = 1'b0; pl = 1'b0; ph = 1'b0; si = 1'b0; dn = 1'b0;
    ps = 2'd3; va = 16'h0000; co = c;
    base = (c == 2'd2) ? 16'hFFFA : ((c == 2'd1) ? 16'hFFFC : 16'hFFFE);
    case (step)
      1: begin act = 1'b1; ps = 2'd0; sp = 1'b1; end
      2: begin act = 1'b1; ps = 2'd1; sp = 1'b1; end
      3: begin act = 1'b1; ps = 2'd2; sp = 1'b1; bf = brk; end
      4: begin act = 1'b1; va = base; pl = 1'b1; end
      5: begin act = 1'b1; va = base + 16'd1; ph = 1'b1; si = 1'b1; dn = 1'b1; end
      default: co = 2'd0;
    endcase
    mw = sp & (c != 2'd1);
    return {act, co, ps, mw, sp, bf, va, pl, ph, si, dn};
  endfunction

  function automatic logic [27:0] obs();
    return {bus.active, bus.cause, bus.push_sel, bus.mem_write, bus.sp_dec, bus.b_flag,
            bus.vec_addr, bus.pcl_load, bus.pch_load, bus.set_i, bus.done};
  endfunction

  task automatic check(input string t, input logic [27:0] got, input logic [27:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, got, want);
    end
  endtask

  task automatic push_exp(input string t, input logic [27:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic push_seq(input string t, input logic [1:0] c, input bit brk);
    for (int s = 1; s <= 5; s++) push_exp($sformatf("%s_s%0d", t, s), exp_vec(s, c, brk));
    push_exp($sformatf("%s_idle", t), exp_vec(0, 2'd0, 1'b0));
  endtask

  task automatic tick();
    logic [27:0] e;
    string       t;
    @(posedge ph2);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, obs(), e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.ready = 1'b1;
    bus.nmi_n = 1'b1;
    bus.irq_n = 1'b1;
    bus.brk_req = 1'b0;
    bus.i_flag = 1'b1;
    bus.insn_boundary = 1'b0;

    #12;
    check("reset_state", obs(), exp_vec(0, 2'd0, 1'b0));
    reset = 1'b1;
    push_seq("rst", 2'd1, 1'b0);
    repeat (6) tick();

    // Unmasked IRQ
    bus.irq_n = 1'b0; bus.i_flag = 1'b0; bus.insn_boundary = 1'b1;
    push_seq("irq", 2'd3, 1'b0);
    tick();
    bus.insn_boundary = 1'b0; bus.irq_n = 1'b1; bus.i_flag = 1'b1;
    repeat (5) tick();

    // BRK ignores i_flag
    bus.irq_n = 1'b0; bus.i_flag = 1'b1; bus.brk_req = 1'b1; bus.insn_boundary = 1'b1;
    push_seq("brk", 2'd3, 1'b1);
    tick();
    bus.insn_boundary = 1'b0; bus.brk_req = 1'b0;
    repeat (5) tick();

    // Masked IRQ without BRK stays idle
    bus.insn_boundary = 1'b1;
    push_exp("masked0", exp_vec(0, 2'd0, 1'b0));
    push_exp("masked1", exp_vec(0, 2'd0, 1'b0));
    tick(); tick();
    bus.insn_boundary = 1'b0; bus.irq_n = 1'b1;

    // NMI edge during PUSH_PCL of an IRQ is deferred
    bus.irq_n = 1'b0; bus.i_flag = 1'b0; bus.insn_boundary = 1'b1;
    push_seq("irq2", 2'd3, 1'b0);
    tick();
    bus.insn_boundary = 1'b0; bus.irq_n = 1'b1; bus.i_flag = 1'b1;
    tick();
    bus.nmi_n = 1'b0;
    repeat (4) tick();
    bus.insn_boundary = 1'b1;
    push_seq("nmi", 2'd2, 1'b0);
    tick();
    bus.insn_boundary = 1'b0; bus.nmi_n = 1'b1;
    repeat (5) tick();
    bus.insn_boundary = 1'b1;
    push_exp("nmi_cleared", exp_vec(0, 2'd0, 1'b0));
    tick();
    bus.insn_boundary = 1'b0;

    // ready=0 for 3 cycles in VEC_LO
    bus.irq_n = 1'b0; bus.i_flag = 1'b0; bus.insn_boundary = 1'b1;
    for (int s = 1; s <= 4; s++) push_exp($sformatf("stall_s%0d", s), exp_vec(s, 2'd3, 1'b0));
    for (int k = 0; k < 3; k++) push_exp($sformatf("stall_hold%0d", k), exp_vec(4, 2'd3, 1'b0));
    push_exp("stall_s5", exp_vec(5, 2'd3, 1'b0));
    push_exp("stall_idle", exp_vec(0, 2'd0, 1'b0));
    tick();
    bus.insn_boundary = 1'b0; bus.irq_n = 1'b1; bus.i_flag = 1'b1;
    repeat (3) tick();
    bus.ready = 1'b0;
    repeat (3) tick();
    bus.ready = 1'b1;
    repeat (2) tick();

    // Reset during PUSH_P of an NMI sequence
    bus.nmi_n = 1'b0;
    push_exp("nmi2_latch", exp_vec(0, 2'd0, 1'b0));
    tick();
    bus.insn_boundary = 1'b1;
    for (int s = 1; s <= 3; s++) push_exp($sformatf("nmi2_s%0d", s), exp_vec(s, 2'd2, 1'b0));
    tick();
    bus.insn_boundary = 1'b0; bus.nmi_n = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("abort_reset", obs(), exp_vec(0, 2'd0, 1'b0));
    #3;
    reset = 1'b1;
    push_seq("rst2", 2'd1, 1'b0);
    repeat (6) tick();

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL queue_empty: observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
